// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the iterative AES-128 encryptor:
//   - FSM state and byte/word/block typedefs
//   - round-constant table (Rcon[1..10])
//   - GF(2^8) xtime and single-column MixColumns
//   - ShiftRows byte-index mapping and its inverse
// Byte index k (0..15) addresses block bits [127-8k -: 8] and holds
// state element s(r,c) with k = 4*c + r (column-major).
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int NR = 10;

  // Round constants; rounds outside 1..10 never occur, so they map to 0.
  function automatic byte_t rcon(input logic [3:0] round);
    byte_t r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by {02} modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the {02 03 01 01} circulant matrix.
  function automatic word_t mix_column(input word_t col);
    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // ShiftRows: destination byte k = (r,c) takes source (r,(c+r) mod 4).
  function automatic int shift_src(input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return 4 * ((c + r) % 4) + r;
  endfunction

  // Inverse mapping; inv_shift_src(shift_src(k)) == k for every k.
  function automatic int inv_shift_src(input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return 4 * ((c - r + 4) % 4) + r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox
// Combinational forward AES S-box.
// Ports:
//   x  in   8  input byte
//   y  out  8  S-box substitution of x
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry for input v sits at bits [8*(255-v) +: 8]; 255-v is simply ~v.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter
// Iterative AES-128 encryptor, one round per clock.
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   in_valid   in   1    pt/key presented
//   in_ready   out  1    idle, can accept a block
//   pt         in   128  plaintext (FIPS-197 byte order)
//   key        in   128  cipher key
//   out_valid  out  1    ct holds a finished ciphertext
//   out_ready  in   1    consumer takes ct
//   ct         out  128  ciphertext
//   busy       out  1    running or holding a result
// Acceptance loads pt^key; each RUN cycle applies one full round and
// advances the key schedule, so the result appears 10 edges after accept.
module aes_enc_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy
);

  fsm_t       fsm_reg, fsm_next;
  logic [3:0] round_reg;
  block_t     state_reg, rk_reg, ct_reg;

  block_t     sb_out, sr_out, mc_out, rk_next, round_out;
  word_t      rot_word, sub_word;
  word_t      w4, w5, w6, w7;
  logic       accept, last_round;

  genvar gi;

  // SubBytes on all 16 state bytes.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_state_sbox
      aes_sbox u_sbox (
        .x (state_reg[127-8*gi -: 8]),
        .y (sb_out[127-8*gi -: 8])
      );
    end
  endgenerate

  // ShiftRows is pure wiring.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shift
      localparam int SRC = shift_src(gi);
      assign sr_out[127-8*gi -: 8] = sb_out[127-8*SRC -: 8];
    end
  endgenerate

  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign mc_out[127-32*gi -: 32] = mix_column(sr_out[127-32*gi -: 32]);
    end
  endgenerate

  // Key schedule: SubWord(RotWord(w3)) uses four more S-boxes.
  assign rot_word = {rk_reg[23:0], rk_reg[31:24]};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_key_sbox
      aes_sbox u_sbox (
        .x (rot_word[31-8*gi -: 8]),
        .y (sub_word[31-8*gi -: 8])
      );
    end
  endgenerate

  assign w4      = rk_reg[127:96] ^ sub_word ^ {rcon(round_reg), 24'h000000};
  assign w5      = rk_reg[95:64] ^ w4;
  assign w6      = rk_reg[63:32] ^ w5;
  assign w7      = rk_reg[31:0]  ^ w6;
  assign rk_next = {w4, w5, w6, w7};

  // Final round skips MixColumns.
  assign last_round = (round_reg == 4'(NR));
  assign round_out  = (last_round ? sr_out : mc_out) ^ rk_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg <= IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  always_comb begin
    fsm_next  = fsm_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fsm_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_round) begin
          fsm_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Datapath. The round counter saturates at 10 (never wraps); ct is
  // written only by the last round so it stays put during rounds 1..9.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round_reg <= 4'd0;
      state_reg <= '0;
      rk_reg    <= '0;
      ct_reg    <= '0;
    end else if (accept) begin
      state_reg <= pt ^ key;
      rk_reg    <= key;
      round_reg <= 4'd1;
    end else if (fsm_reg == RUN) begin
      state_reg <= round_out;
      rk_reg    <= rk_next;
      if (last_round) begin
        ct_reg <= round_out;
      end else begin
        round_reg <= round_reg + 4'd1;
      end
    end
  end

  assign ct = ct_reg;

endmodule
